// File: rtl/decode_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and the decoded control bundle.
// The out_illegal field exists only when DECODE_ILLEGAL_EN is defined.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LOAD  = 6'h20;
  localparam logic [5:0] OP_STORE = 6'h30;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JMP   = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOP = 6'h00;

  localparam logic [2:0] ALU_OP_NONE = 3'd0;
  localparam logic [2:0] ALU_OP_ADD  = 3'd1;
  localparam logic [2:0] ALU_OP_SUB  = 3'd2;
  localparam logic [2:0] ALU_OP_AND  = 3'd3;
  localparam logic [2:0] ALU_OP_OR   = 3'd4;
  localparam logic [2:0] ALU_OP_SLT  = 3'd5;
  localparam logic [2:0] ALU_OP_BEQ  = 3'd6;

  // Width-independent control fields; register ids, PC and addr_info live beside it.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
    logic       itype;
    logic       is_branch;
    logic       is_jump;
`ifdef DECODE_ILLEGAL_EN
    logic       illegal;
`endif
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: instruction word -> control bundle,
// register ids and source-usage flags. Illegal flagging only under DECODE_ILLEGAL_EN.
module decode_comb
  import decode_pkg::*;
#(
  parameter int INSN_W      = 32,
  parameter int REG_AW      = 5,
  parameter int ADDR_INFO_W = 26
) (
  input  logic [INSN_W-1:0]      insn_i,
  output ctrl_t                  ctrl_o,
  output logic [REG_AW-1:0]      rs_o,
  output logic [REG_AW-1:0]      rt_o,
  output logic [REG_AW-1:0]      write_reg_o,
  output logic [ADDR_INFO_W-1:0] addr_info_o,
  output logic                   uses_rs_o,
  output logic                   uses_rt_o
);

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rd;

  assign opcode      = insn_i[INSN_W-1 -: 6];
  assign funct       = insn_i[5:0];
  assign rs_o        = insn_i[21 +: REG_AW];
  assign rt_o        = insn_i[16 +: REG_AW];
  assign rd          = insn_i[11 +: REG_AW];
  assign addr_info_o = insn_i[ADDR_INFO_W-1:0];

  // Unknown encodings fall through with every control bit cleared, so nothing is ever X.
  always_comb begin
    ctrl_o      = CTRL_NONE;
    write_reg_o = rt_o;
    uses_rs_o   = 1'b0;
    uses_rt_o   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        write_reg_o  = rd;
        uses_rs_o    = 1'b1;
        uses_rt_o    = 1'b1;
        ctrl_o.wb_en = 1'b1;
        case (funct)
          FN_ADD: ctrl_o.alu_op = ALU_OP_ADD;
          FN_SUB: ctrl_o.alu_op = ALU_OP_SUB;
          FN_AND: ctrl_o.alu_op = ALU_OP_AND;
          FN_OR:  ctrl_o.alu_op = ALU_OP_OR;
          FN_SLT: ctrl_o.alu_op = ALU_OP_SLT;
          FN_NOP: ctrl_o.wb_en  = 1'b0;
          default: begin
            ctrl_o.wb_en = 1'b0;
            uses_rs_o    = 1'b0;
            uses_rt_o    = 1'b0;
`ifdef DECODE_ILLEGAL_EN
            ctrl_o.illegal = 1'b1;
`endif
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_o.alu_op = ALU_OP_ADD;
        ctrl_o.itype  = 1'b1;
        ctrl_o.wb_en  = 1'b1;
        uses_rs_o     = 1'b1;
      end
      OP_LOAD: begin
        ctrl_o.alu_op   = ALU_OP_ADD;
        ctrl_o.itype    = 1'b1;
        ctrl_o.mem_read = 1'b1;
        ctrl_o.wb_en    = 1'b1;
        uses_rs_o       = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.alu_op    = ALU_OP_ADD;
        ctrl_o.itype     = 1'b1;
        ctrl_o.mem_write = 1'b1;
        uses_rs_o        = 1'b1;
        uses_rt_o        = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.alu_op    = ALU_OP_BEQ;
        ctrl_o.is_branch = 1'b1;
        uses_rs_o        = 1'b1;
        uses_rt_o        = 1'b1;
      end
      OP_JMP: ctrl_o.is_jump = 1'b1;
      default: begin
`ifdef DECODE_ILLEGAL_EN
        ctrl_o.illegal = 1'b1;
`endif
      end
    endcase
    if (write_reg_o == '0) ctrl_o.wb_en = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered IF/ID -> ID/EX decode stage with valid/ready handshake, flush and
// single-bubble load-use stall. DECODE_ILLEGAL_EN enables the registered out_illegal flag.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSN_W      = 32,
  parameter int REG_AW      = 5,
  parameter int ADDR_INFO_W = 26,
  parameter int PC_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSN_W-1:0]      in_insn,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [2:0]             out_alu_op,
  output logic [REG_AW-1:0]      out_rs,
  output logic [REG_AW-1:0]      out_rt,
  output logic [REG_AW-1:0]      out_write_reg,
  output logic                   out_wb_en,
  output logic                   out_mem_read,
  output logic                   out_mem_write,
  output logic                   out_itype,
  output logic                   out_is_branch,
  output logic                   out_is_jump,
  output logic [ADDR_INFO_W-1:0] out_addr_info,
  output logic                   out_illegal,
  output logic                   stall
);

  ctrl_t                  dec_ctrl;
  logic [REG_AW-1:0]      dec_rs, dec_rt, dec_wr;
  logic [ADDR_INFO_W-1:0] dec_addr;
  logic                   dec_uses_rs, dec_uses_rt;

  decode_comb #(
    .INSN_W      (INSN_W),
    .REG_AW      (REG_AW),
    .ADDR_INFO_W (ADDR_INFO_W)
  ) u_decode (
    .insn_i      (in_insn),
    .ctrl_o      (dec_ctrl),
    .rs_o        (dec_rs),
    .rt_o        (dec_rt),
    .write_reg_o (dec_wr),
    .addr_info_o (dec_addr),
    .uses_rs_o   (dec_uses_rs),
    .uses_rt_o   (dec_uses_rt)
  );

  logic                   valid_q, valid_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [REG_AW-1:0]      rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
  logic [ADDR_INFO_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic                   hazard, load;

  // A LOAD sitting in the output register whose destination feeds the incoming instruction.
  assign hazard = valid_q && ctrl_q.mem_read && (wr_q != '0) && in_valid &&
                  ((dec_uses_rs && (dec_rs == wr_q)) || (dec_uses_rt && (dec_rt == wr_q)));
  assign in_ready = flush || ((!valid_q || out_ready) && !hazard);
  assign load     = in_valid && in_ready && !flush;
  assign stall    = hazard;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      rs_d    = dec_rs;
      rt_d    = dec_rt;
      wr_d    = dec_wr;
      addr_d  = dec_addr;
      pc_d    = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NONE;
      rs_q    <= '0;
      rt_q    <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_alu_op    = ctrl_q.alu_op;
  assign out_rs        = rs_q;
  assign out_rt        = rt_q;
  assign out_write_reg = wr_q;
  assign out_wb_en     = ctrl_q.wb_en;
  assign out_mem_read  = ctrl_q.mem_read;
  assign out_mem_write = ctrl_q.mem_write;
  assign out_itype     = ctrl_q.itype;
  assign out_is_branch = ctrl_q.is_branch;
  assign out_is_jump   = ctrl_q.is_jump;
  assign out_addr_info = addr_q;
`ifdef DECODE_ILLEGAL_EN
  assign out_illegal   = ctrl_q.illegal;
`else
  assign out_illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, directed handshake
// sequences and a randomized run against a transaction-level reference model.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_insn, in_pc, out_pc;
  logic [2:0]  out_alu_op;
  logic [4:0]  out_rs, out_rt, out_write_reg;
  logic        out_wb_en, out_mem_read, out_mem_write, out_itype;
  logic        out_is_branch, out_is_jump, out_illegal, stall;
  logic [25:0] out_addr_info;

  int total = 0;
  int bad   = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_alu_op(out_alu_op),
    .out_rs(out_rs), .out_rt(out_rt), .out_write_reg(out_write_reg),
    .out_wb_en(out_wb_en), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_itype(out_itype), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_addr_info(out_addr_info), .out_illegal(out_illegal), .stall(stall)
  );

  always #5 clk = ~clk;

  // Expected architectural view of one decoded instruction.
  typedef struct packed {
    logic [2:0]  alu;
    logic [4:0]  rs, rt, wr;
    logic        wb, mr, mw, it, br, jp, il;
    logic [25:0] ai;
    logic        usesRs, usesRt;
  } exp_t;

  typedef struct {
    logic [31:0] insn;
    logic [2:0]  alu;
    logic [4:0]  wr;
    logic        wb, mr, mw, it, br, jp, il;
  } vec_t;

  exp_t        expB;
  logic        expValid;
  logic [31:0] expPc;
  logic        lastStall, lastInReady;

  function automatic exp_t refDecode(input logic [31:0] insn);
    exp_t e;
    logic [5:0] op, fn;
    logic known, writes;
    op = insn[31:26];
    fn = insn[5:0];
    e = '0;
    e.rs = insn[25:21];
    e.rt = insn[20:16];
    e.ai = insn[25:0];
    e.wr = (op == 6'h00) ? insn[15:11] : insn[20:16];
    known = 1'b1;
    if (op == 6'h00) begin
      case (fn)
        6'h20: e.alu = 3'd1;
        6'h22: e.alu = 3'd2;
        6'h24: e.alu = 3'd3;
        6'h25: e.alu = 3'd4;
        6'h2A: e.alu = 3'd5;
        6'h00: e.alu = 3'd0;
        default: known = 1'b0;
      endcase
      writes   = known && (fn != 6'h00);
      e.usesRs = known;
      e.usesRt = known;
    end else begin
      e.it = (op == 6'h08) || (op == 6'h20) || (op == 6'h30);
      e.mr = (op == 6'h20);
      e.mw = (op == 6'h30);
      e.br = (op == 6'h04);
      e.jp = (op == 6'h02);
      known = e.it || e.br || e.jp;
      e.alu = e.it ? 3'd1 : (e.br ? 3'd6 : 3'd0);
      writes = (op == 6'h08) || (op == 6'h20);
      e.usesRs = e.it || e.br;
      e.usesRt = e.mw || e.br;
    end
    e.wb = writes && (e.wr != 5'd0);
    e.il = ILL && !known;
    return e;
  endfunction

  function automatic logic [63:0] packB(input exp_t e);
    return {13'b0, e.alu, e.rs, e.rt, e.wr, e.wb, e.mr, e.mw, e.it, e.br, e.jp, e.il, e.ai};
  endfunction

  function automatic logic [63:0] packOut();
    return {13'b0, out_alu_op, out_rs, out_rt, out_write_reg, out_wb_en, out_mem_read,
            out_mem_write, out_itype, out_is_branch, out_is_jump, out_illegal, out_addr_info};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    expValid = 1'b0;
    expB     = '0;
    expPc    = '0;
  endtask

  // Called at posedge+1: drives one cycle, checks combinational outputs at the
  // falling edge, advances the model and checks registered outputs after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                               input logic fl, input logic rdy);
    exp_t d;
    logic hz, rIn;
    in_valid  = v;
    in_insn   = insn;
    in_pc     = pc;
    flush     = fl;
    out_ready = rdy;
    @(negedge clk);
    d   = refDecode(insn);
    hz  = expValid && expB.mr && (expB.wr != 5'd0) && v &&
          ((d.usesRs && d.rs == expB.wr) || (d.usesRt && d.rt == expB.wr));
    rIn = fl || ((!expValid || rdy) && !hz);
    lastStall   = stall;
    lastInReady = in_ready;
    checkOutput("stall", stall, hz);
    checkOutput("in_ready", in_ready, rIn);
    if (fl) expValid = 1'b0;
    else if (v && rIn) begin
      expValid = 1'b1;
      expB     = d;
      expPc    = pc;
    end else if (rdy) expValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("out_valid", out_valid, expValid);
    checkOutput("bundle", packOut(), packB(expB));
    checkOutput("out_pc", out_pc, expPc);
  endtask

  function automatic logic [31:0] randInsn();
    logic [5:0] ops [8] = '{6'h00, 6'h08, 6'h20, 6'h30, 6'h04, 6'h02, 6'h3F, 6'h11};
    logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    op = ops[$urandom_range(7)];
    rs = 5'($urandom_range(3));
    rt = 5'($urandom_range(3));
    rd = 5'($urandom_range(3));
    if (op == 6'h00) return {op, rs, rt, rd, 5'($urandom), fns[$urandom_range(6)]};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_ADDI = 32'h20050007;
  localparam logic [31:0] I_LOAD = 32'h80240000;
  localparam logic [31:0] I_SUB  = 32'h00823022;

  initial begin
    vec_t vecs[14];
    vecs[0]  = '{32'h00221820, 3'd1, 5'd3, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h00823022, 3'd2, 5'd6, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{32'h00223824, 3'd3, 5'd7, 1, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{32'h00224025, 3'd4, 5'd8, 1, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{32'h0022482A, 3'd5, 5'd9, 1, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{32'h00000000, 3'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{32'h20050007, 3'd1, 5'd5, 1, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{32'h20200001, 3'd1, 5'd0, 0, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{32'h80240000, 3'd1, 5'd4, 1, 1, 0, 1, 0, 0, 0};
    vecs[9]  = '{32'hC0240008, 3'd1, 5'd4, 0, 0, 1, 1, 0, 0, 0};
    vecs[10] = '{32'h10220010, 3'd6, 5'd2, 0, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{32'h08000040, 3'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0};
    vecs[12] = '{32'hFC000000, 3'd0, 5'd0, 0, 0, 0, 0, 0, 0, ILL};
    vecs[13] = '{32'h0022183F, 3'd0, 5'd3, 0, 0, 0, 0, 0, 0, ILL};

    rst_n = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    resetModel();
    #12;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset stall", stall, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset bundle", packOut(), 64'd0);
    checkOutput("reset out_pc", out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode table: each instruction issued alone, then drained.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].insn, 32'h1000 + 32'(i * 4), 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d fields", i),
                  {out_alu_op, out_write_reg, out_wb_en, out_mem_read, out_mem_write,
                   out_itype, out_is_branch, out_is_jump, out_illegal},
                  {vecs[i].alu, vecs[i].wr, vecs[i].wb, vecs[i].mr, vecs[i].mw,
                   vecs[i].it, vecs[i].br, vecs[i].jp, vecs[i].il});
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    end

    // Back-to-back stream, one per cycle.
    applyStimulus(1'b1, I_ADD, 32'h200, 1'b0, 1'b1);
    checkOutput("stream0 alu/wr/itype", {out_alu_op, out_write_reg, out_itype}, {3'd1, 5'd3, 1'b0});
    applyStimulus(1'b1, I_ADDI, 32'h204, 1'b0, 1'b1);
    checkOutput("stream1 alu/wr/itype", {out_valid, out_alu_op, out_write_reg, out_itype},
                {1'b1, 3'd1, 5'd5, 1'b1});
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Load-use: exactly one bubble.
    applyStimulus(1'b1, I_LOAD, 32'h300, 1'b0, 1'b1);
    applyStimulus(1'b1, I_SUB, 32'h304, 1'b0, 1'b1);
    checkOutput("loaduse stall", lastStall, 1);
    checkOutput("loaduse bubble", out_valid, 0);
    applyStimulus(1'b1, I_SUB, 32'h304, 1'b0, 1'b1);
    checkOutput("loaduse stall cleared", lastStall, 0);
    checkOutput("loaduse sub issue", {out_valid, out_alu_op, out_write_reg}, {1'b1, 3'd2, 5'd6});
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Backpressure for three cycles, then release.
    applyStimulus(1'b1, I_ADD, 32'h400, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, I_ADDI, 32'h404, 1'b0, 1'b0);
      checkOutput("hold in_ready", lastInReady, 0);
      checkOutput("hold bundle", {out_valid, out_alu_op, out_write_reg, out_pc[15:0]},
                  {1'b1, 3'd1, 5'd3, 16'h0400});
    end
    applyStimulus(1'b1, I_ADDI, 32'h404, 1'b0, 1'b1);
    checkOutput("release in_ready", lastInReady, 1);
    checkOutput("release next", {out_valid, out_write_reg, out_pc[15:0]}, {1'b1, 5'd5, 16'h0404});

    // Flush kills both the held bundle and the presented instruction.
    applyStimulus(1'b1, I_ADD, 32'h500, 1'b0, 1'b0);
    applyStimulus(1'b1, I_ADDI, 32'h504, 1'b1, 1'b0);
    checkOutput("flush valid", out_valid, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("flush never appears", out_valid, 0);

    // Asynchronous reset mid-stream.
    applyStimulus(1'b1, I_ADD, 32'h600, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset alu_op", out_alu_op, 0);
    checkOutput("midreset in_ready", in_ready, 1);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(9) < 7, randInsn(), $urandom,
                    $urandom_range(19) == 0, $urandom_range(9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
